// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with unified word-addressed memory, 32-entry register
// file and a flat 4096-entry machine CSR array; one instruction retires per clock.

module rv32i_mem #(
    parameter int MEM_WORDS = 65536
) (
    input  logic                         clk,
    input  logic [$clog2(MEM_WORDS)-1:0] iidx,
    output logic [31:0]                  idata,
    input  logic [$clog2(MEM_WORDS)-1:0] didx,
    output logic [31:0]                  rdata,
    input  logic                         we,
    input  logic [3:0]                   wstrb,
    input  logic [31:0]                  wdata
);
    logic [31:0] m [0:MEM_WORDS-1];

    assign idata = m[iidx];
    assign rdata = m[didx];

    // Only the enabled byte lanes are written; the rest of the word is kept.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) m[didx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

module rv32i_core #(
    parameter int          MEM_WORDS = 65536,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    logic [31:0] pc;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    logic [31:0] inst, rdata, daddr, wdata;
    logic        mem_we;
    logic [3:0]  wstrb;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1_idx, rs2_idx;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rv1, rv2, alu_b, alu_out, ld_sh;
    logic [11:0] csr_addr;
    logic [31:0] csr_old, csr_src;
    logic [1:0]  lane;
    logic        take;

    logic [31:0] next_pc, rd_val, csr_wval, cause;
    logic        rd_we, csr_we, trap;

    rv32i_mem #(.MEM_WORDS(MEM_WORDS)) memory (
        .clk   (clk),
        .iidx  (pc[AW+1:2]),
        .idata (inst),
        .didx  (daddr[AW+1:2]),
        .rdata (rdata),
        .we    (mem_we & ~rst),
        .wstrb (wstrb),
        .wdata (wdata)
    );

    // Address bits above the memory size alias onto the same words.
    logic unused_daddr_hi;
    assign unused_daddr_hi = ^daddr[31:AW+2];

    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign f3       = inst[14:12];
    assign rs1_idx  = inst[19:15];
    assign rs2_idx  = inst[24:20];
    assign imm_i    = {{20{inst[31]}}, inst[31:20]};
    assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u    = {inst[31:12], 12'h000};
    assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign rv1      = (rs1_idx == 5'd0) ? 32'h0 : rs[rs1_idx];
    assign rv2      = (rs2_idx == 5'd0) ? 32'h0 : rs[rs2_idx];

    assign csr_addr = inst[31:20];
    assign csr_old  = (csr_addr == 12'hF14) ? 32'h0 : csr[csr_addr];
    assign csr_src  = f3[2] ? {27'h0, rs1_idx} : rv1;

    assign daddr    = rv1 + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign lane     = daddr[1:0];
    assign ld_sh    = rdata >> {lane, 3'b000};
    assign alu_b    = (opcode == OP_REG) ? rv2 : imm_i;

    // inst[30] selects SUB only for register ops, and SRA/SRAI for both forms.
    always_comb begin
        alu_out = 32'h0;
        case (f3)
            3'b000: alu_out = (opcode == OP_REG && inst[30]) ? rv1 - alu_b : rv1 + alu_b;
            3'b001: alu_out = rv1 << alu_b[4:0];
            3'b010: alu_out = {31'h0, $signed(rv1) < $signed(alu_b)};
            3'b011: alu_out = {31'h0, rv1 < alu_b};
            3'b100: alu_out = rv1 ^ alu_b;
            3'b101: alu_out = inst[30] ? $unsigned($signed(rv1) >>> alu_b[4:0]) : rv1 >> alu_b[4:0];
            3'b110: alu_out = rv1 | alu_b;
            3'b111: alu_out = rv1 & alu_b;
            default: alu_out = 32'h0;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (f3)
            3'b000: take = (rv1 == rv2);
            3'b001: take = (rv1 != rv2);
            3'b100: take = ($signed(rv1) <  $signed(rv2));
            3'b101: take = ($signed(rv1) >= $signed(rv2));
            3'b110: take = (rv1 <  rv2);
            3'b111: take = (rv1 >= rv2);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        next_pc  = pc + 32'd4;
        rd_we    = 1'b0;
        rd_val   = alu_out;
        mem_we   = 1'b0;
        wstrb    = 4'b0000;
        wdata    = rv2 << {lane, 3'b000};
        csr_we   = 1'b0;
        csr_wval = csr_src;
        trap     = 1'b0;
        cause    = 32'd0;
        case (opcode)
            OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
            OP_AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_val  = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                rd_we   = 1'b1;
                rd_val  = pc + 32'd4;
                next_pc = (rv1 + imm_i) & ~32'd1;
            end
            OP_BRANCH: if (take) next_pc = pc + imm_b;
            OP_LOAD: begin
                rd_we = 1'b1;
                case (f3)
                    3'b000: rd_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
                    3'b001: rd_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
                    3'b010: rd_val = rdata;
                    3'b100: rd_val = {24'h0, ld_sh[7:0]};
                    3'b101: rd_val = {16'h0, ld_sh[15:0]};
                    default: rd_we = 1'b0;
                endcase
            end
            OP_STORE: begin
                mem_we = 1'b1;
                case (f3)
                    3'b000:  wstrb = 4'b0001 << lane;
                    3'b001:  wstrb = 4'b0011 << lane;
                    3'b010:  wstrb = 4'b1111;
                    default: mem_we = 1'b0;
                endcase
            end
            OP_IMM, OP_REG: rd_we = 1'b1;
            OP_SYSTEM: begin
                if (f3 == 3'b000) begin
                    case (inst[31:20])
                        12'h000: begin trap = 1'b1; cause = 32'd11; next_pc = csr[12'h305] & ~32'd3; end
                        12'h001: begin trap = 1'b1; cause = 32'd3;  next_pc = csr[12'h305] & ~32'd3; end
                        12'h302: next_pc = csr[12'h341];
                        default: ;
                    endcase
                end else if (f3[1:0] != 2'b00) begin
                    rd_we  = 1'b1;
                    rd_val = csr_old;
                    case (f3[1:0])
                        2'b01: begin csr_we = 1'b1; csr_wval = csr_src; end
                        2'b10: begin csr_we = (rs1_idx != 5'd0); csr_wval = csr_old | csr_src; end
                        default: begin csr_we = (rs1_idx != 5'd0); csr_wval = csr_old & ~csr_src; end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++)   rs[i]  <= 32'h0;
            for (int i = 0; i < 4096; i++) csr[i] <= 32'h0;
        end else begin
            pc <= next_pc;
            if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
            if (trap) begin
                csr[12'h341] <= pc;
                csr[12'h342] <= cause;
            end else if (csr_we) begin
                csr[csr_addr] <= csr_wval;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: directed programs plus random programs, all checked
// cycle by cycle against an instruction-level model with byte-addressed memory.

module tb_rv32i_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;

    rv32i_core dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [7:0]  mm [0:262143];
    logic [31:0] mx [0:31];
    logic [31:0] mpc;
    logic [31:0] mcsr [int];
    logic [31:0] prog [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ld32(input logic [31:0] a);
        logic [17:0] b;
        b = {a[17:2], 2'b00};
        return {mm[b + 18'd3], mm[b + 18'd2], mm[b + 18'd1], mm[b]};
    endfunction

    function automatic logic [31:0] csr_rd(input int a);
        if (a == 'hF14) return 32'h0;
        return mcsr.exists(a) ? mcsr[a] : 32'h0;
    endfunction

    task automatic poke(input int w, input logic [31:0] v);
        logic [17:0] b;
        dut.memory.m[w] = v;
        b = 18'(w * 4);
        mm[b]         = v[7:0];
        mm[b + 18'd1] = v[15:8];
        mm[b + 18'd2] = v[23:16];
        mm[b + 18'd3] = v[31:24];
    endtask

    task automatic model_reset();
        mpc = 32'h0;
        for (int r = 0; r < 32; r++) mx[r] = 32'h0;
        mcsr.delete();
    endtask

    // Architectural reference: executes the instruction at mpc.
    task automatic model_step();
        logic [31:0] ins, a, b, opb, immi, res, npc, ea, old, src;
        logic [17:0] e;
        logic [15:0] h;
        logic [2:0]  f3;
        logic [4:0]  rd;
        bit          wr, take;
        int          ca;
        ins  = ld32(mpc);
        rd   = ins[11:7];
        f3   = ins[14:12];
        a    = mx[ins[19:15]];
        b    = mx[ins[24:20]];
        immi = {{20{ins[31]}}, ins[31:20]};
        npc  = mpc + 4;
        wr   = 0;
        res  = 0;
        take = 0;
        case (ins[6:0])
            7'h37: begin res = {ins[31:12], 12'h0}; wr = 1; end
            7'h17: begin res = mpc + {ins[31:12], 12'h0}; wr = 1; end
            7'h6f: begin
                res = mpc + 4; wr = 1;
                npc = mpc + {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'h67: begin res = mpc + 4; wr = 1; npc = (a + immi) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (f3)
                    0: take = a == b;
                    1: take = a != b;
                    4: take = $signed(a) < $signed(b);
                    5: take = !($signed(a) < $signed(b));
                    6: take = a < b;
                    7: take = !(a < b);
                    default: take = 0;
                endcase
                if (take) npc = mpc + {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h03: begin
                ea = a + immi; e = ea[17:0]; wr = 1;
                h  = {mm[e + 18'd1], mm[e]};
                case (f3)
                    0: res = {{24{mm[e][7]}}, mm[e]};
                    1: res = {{16{h[15]}}, h};
                    2: res = ld32(ea);
                    4: res = {24'h0, mm[e]};
                    5: res = {16'h0, h};
                    default: wr = 0;
                endcase
            end
            7'h23: begin
                ea = a + {{20{ins[31]}}, ins[31:25], ins[11:7]}; e = ea[17:0];
                if (f3 <= 2) mm[e] = b[7:0];
                if (f3 == 1 || f3 == 2) mm[e + 18'd1] = b[15:8];
                if (f3 == 2) begin mm[e + 18'd2] = b[23:16]; mm[e + 18'd3] = b[31:24]; end
            end
            7'h13, 7'h33: begin
                opb = (ins[6:0] == 7'h33) ? b : immi;
                wr  = 1;
                case (f3)
                    0: res = (ins[6:0] == 7'h33 && ins[30]) ? a - opb : a + opb;
                    1: res = a << opb[4:0];
                    2: res = ($signed(a) < $signed(opb)) ? 1 : 0;
                    3: res = (a < opb) ? 1 : 0;
                    4: res = a ^ opb;
                    5: res = ins[30] ? $unsigned($signed(a) >>> opb[4:0]) : a >> opb[4:0];
                    6: res = a | opb;
                    default: res = a & opb;
                endcase
            end
            7'h73: begin
                if (f3 == 0) begin
                    if (ins[31:20] == 0 || ins[31:20] == 1) begin
                        mcsr['h341] = mpc;
                        mcsr['h342] = ins[20] ? 3 : 11;
                        npc = csr_rd('h305) & 32'hFFFF_FFFC;
                    end else if (ins[31:20] == 'h302) begin
                        npc = csr_rd('h341);
                    end
                end else if (f3 != 4) begin
                    ca  = int'(ins[31:20]);
                    old = csr_rd(ca);
                    src = f3[2] ? {27'h0, ins[19:15]} : a;
                    res = old; wr = 1;
                    if (f3[1:0] == 1) mcsr[ca] = src;
                    else if (ins[19:15] != 0) mcsr[ca] = (f3[1:0] == 2) ? (old | src) : (old & ~src);
                end
            end
            default: ;
        endcase
        if (wr && rd != 0) mx[rd] = res;
        mpc = npc;
    endtask

    task automatic check_regs();
        int bad;
        bad = -1;
        for (int r = 0; r < 32; r++) if (dut.rs[r] !== mx[r] && bad < 0) bad = r;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL regs at pc %08h: x%0d got %08h expected %08h", mpc, bad, dut.rs[bad], mx[bad]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", dut.pc, mpc);
            check_regs();
            model_step();
        end
    end

    function automatic logic [31:0] enc_i(input logic [31:0] op, f3, rd, rs1, imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd, op);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] f3, rs2, rs1, imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] f3, rs1, rs2, imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] op, rd, imm20);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] rd, imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    task automatic begin_prog();
        chk_en = 1'b0;
        rst    = 1'b1;
        prog.delete();
        for (int w = 0; w < 512; w++)     poke(w, NOP);
        for (int w = 1024; w < 1280; w++) poke(w, $urandom);
    endtask

    task automatic start(input int n);
        foreach (prog[i]) poke(i, prog[i]);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_insn();
        int lf [5] = '{0, 1, 2, 4, 5};
        int bf [6] = '{0, 1, 4, 5, 6, 7};
        int cf [6] = '{1, 2, 3, 5, 6, 7};
        int ca [5] = '{'h340, 'h341, 'h300, 'hF14, 'h7C0};
        int k, rd, r1, r2, f3, f7, imm;
        k  = $urandom_range(0, 9);
        rd = $urandom_range(1, 30);
        r1 = $urandom_range(0, 31);
        r2 = $urandom_range(0, 31);
        case (k)
            0: begin
                f3 = $urandom_range(0, 7);
                f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 'h20 : 0;
                return enc_r(f7, r2, r1, f3, rd, 'h33);
            end
            2: return enc_u(($urandom_range(0, 1) == 1) ? 'h37 : 'h17, rd, $urandom);
            3: begin
                f3  = lf[$urandom_range(0, 4)];
                imm = $urandom_range(0, 1023);
                if (f3 == 2) imm = imm & ~3;
                else if (f3 == 1 || f3 == 5) imm = imm & ~1;
                return enc_i('h03, f3, rd, 31, imm);
            end
            4: begin
                f3  = $urandom_range(0, 2);
                imm = $urandom_range(0, 1023) & ~((1 << f3) - 1);
                return enc_s(f3, r2, 31, imm);
            end
            5: return enc_b(bf[$urandom_range(0, 5)], r1, r2, 4 * $urandom_range(1, 4));
            6: return enc_j(rd, 4 * $urandom_range(1, 4));
            7: return enc_i('h73, cf[$urandom_range(0, 5)], rd, r1, ca[$urandom_range(0, 4)]);
            8: return ($urandom_range(0, 1) == 1) ? 32'h0000_000F : enc_i('h0B, 0, rd, r1, $urandom);
            default: begin
                f3  = $urandom_range(0, 7);
                imm = $urandom;
                if (f3 == 1) imm = $urandom_range(0, 31);
                if (f3 == 5) imm = $urandom_range(0, 31) | (($urandom_range(0, 1) == 1) ? 'h400 : 0);
                return enc_i('h13, f3, rd, r1, imm);
            end
        endcase
    endfunction

    initial begin
        int bad;
        int cl [4] = '{'h340, 'h341, 'h300, 'h7C0};

        // Reset into a NOP sled.
        begin_prog();
        start(1);
        check("reset pc", dut.pc, 32'h0);
        bad = 0;
        for (int r = 0; r < 32; r++) if (dut.rs[r] !== 32'h0) bad++;
        check("reset regs nonzero count", bad, 0);
        run(4);
        check("pc after 4 nops", dut.pc, 32'h10);

        // ALU
        begin_prog();
        prog.push_back(enc_i('h13, 0, 1, 0, -1));
        prog.push_back(enc_i('h13, 7, 3, 1, 'h0F0));
        prog.push_back(enc_r('h20, 1, 0, 0, 4, 'h33));
        prog.push_back(enc_j(0, 0));
        start(1);
        run(3);
        check("alu x3", dut.rs[3], 32'h0000_00F0);
        check("alu x4", dut.rs[4], 32'h1);
        check("alu x1", dut.rs[1], 32'hFFFF_FFFF);
        check("model alu x3", mx[3], 32'h0000_00F0);

        // Byte lanes
        begin_prog();
        poke(64, 32'h1122_3344);
        prog.push_back(enc_i('h13, 0, 5, 0, 'hAA));
        prog.push_back(enc_s(0, 5, 0, 'h101));
        prog.push_back(enc_i('h03, 2, 6, 0, 'h100));
        prog.push_back(enc_i('h03, 0, 7, 0, 'h101));
        prog.push_back(enc_i('h03, 4, 8, 0, 'h101));
        prog.push_back(enc_i('h03, 1, 9, 0, 'h102));
        prog.push_back(enc_j(0, 0));
        start(1);
        run(6);
        check("sb word", dut.memory.m[64], 32'h1122_AA44);
        check("lw", dut.rs[6], 32'h1122_AA44);
        check("lb", dut.rs[7], 32'hFFFF_FFAA);
        check("lbu", dut.rs[8], 32'h0000_00AA);
        check("lh", dut.rs[9], 32'h0000_1122);
        check("model lb", mx[7], 32'hFFFF_FFAA);

        // Branch / jump
        begin_prog();
        prog.push_back(enc_i('h13, 0, 1, 0, 1));
        prog.push_back(enc_b(1, 1, 0, 8));
        prog.push_back(enc_i('h13, 0, 2, 0, 7));
        prog.push_back(enc_j(5, 8));
        prog.push_back(enc_i('h13, 0, 2, 0, 9));
        prog.push_back(enc_i('h13, 0, 6, 0, 'h21));
        prog.push_back(enc_i('h67, 0, 7, 6, 0));
        prog.push_back(enc_i('h13, 0, 2, 0, 3));
        prog.push_back(enc_j(0, 0));
        start(1);
        run(5);
        check("jalr target", dut.pc, 32'h20);
        check("skipped x2", dut.rs[2], 32'h0);
        check("jal link", dut.rs[5], 32'h10);
        check("jalr link", dut.rs[7], 32'h1C);

        // ECALL / MRET
        begin_prog();
        prog.push_back(enc_i('h13, 0, 1, 0, 'h40));
        prog.push_back(enc_i('h73, 1, 0, 1, 'h305));
        for (int i = 2; i < 8; i++) prog.push_back(NOP);
        prog.push_back(32'h0000_0073);
        for (int i = 9; i < 16; i++) prog.push_back(NOP);
        prog.push_back(32'h3020_0073);
        start(1);
        run(9);
        check("ecall pc", dut.pc, 32'h40);
        check("ecall mepc", dut.csr[12'h341], 32'h20);
        check("ecall mcause", dut.csr[12'h342], 32'd11);
        check("model mcause", csr_rd('h342), 32'd11);
        run(1);
        check("mret pc", dut.pc, 32'h20);

        // EBREAK with low mtvec bits set
        begin_prog();
        prog.push_back(enc_i('h13, 0, 1, 0, 'h83));
        prog.push_back(enc_i('h73, 1, 0, 1, 'h305));
        prog.push_back(32'h0010_0073);
        start(1);
        run(3);
        check("ebreak pc", dut.pc, 32'h80);
        check("ebreak mepc", dut.csr[12'h341], 32'h8);
        check("ebreak mcause", dut.csr[12'h342], 32'd3);

        // A store sitting at pc while reset is held must not commit.
        begin_prog();
        poke(64, 32'hDEAD_BEEF);
        prog.push_back(enc_s(2, 0, 0, 'h100));
        prog.push_back(enc_j(0, 0));
        start(3);
        check("store under reset", dut.memory.m[64], 32'hDEAD_BEEF);
        run(1);
        check("store after reset", dut.memory.m[64], 32'h0);

        // Random programs
        for (int t = 0; t < 6; t++) begin
            begin_prog();
            prog.push_back(enc_u('h37, 31, 1));
            for (int i = 0; i < 6; i++) begin
                bad = $urandom_range(1, 30);
                prog.push_back(enc_u('h37, bad, $urandom));
                prog.push_back(enc_i('h13, 0, bad, bad, $urandom));
            end
            for (int i = 0; i < 200; i++) prog.push_back(rand_insn());
            for (int i = 0; i < 5; i++) prog.push_back(NOP);
            prog.push_back(enc_j(0, 0));
            start(1);
            run(prog.size() + 5);
            bad = -1;
            for (int w = 1024; w < 1280; w++) if (dut.memory.m[w] !== ld32(w * 4) && bad < 0) bad = w;
            vectors++;
            if (bad >= 0) begin
                miscompares++;
                $display("FAIL data word %0d: got %08h expected %08h", bad, dut.memory.m[bad], ld32(bad * 4));
            end
            foreach (cl[i]) check($sformatf("csr %03h", cl[i]), dut.csr[cl[i]], csr_rd(cl[i]));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Single-cycle RV32I processor with unified on-chip instruction/data memory, a 32-entry register file and a flat machine-mode CSR array.
- The block is self-contained: its only ports are clock and reset.
- Memory is preloaded by the bench with a hex image and runs the riscv-tests rv32ui-p programs.
- Pass/fail is read from architectural register x3 (gp): gp == 1 means pass.

Parameters:
- MEM_WORDS, 65536, number of 32-bit words in unified memory (256 KiB).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.

Behaviour:
- Hierarchy and names are fixed because benches access them directly:
  - Memory lives in instance "memory" as array m[0:MEM_WORDS-1] of 32-bit words.
  - Register file is rs[0:31] of 32 bits.
  - CSRs are csr[0:4095] of 32 bits.
- Hex image format: one 32-bit word per line, word 0 at index 0.
- Memory addressing:
  - Word index = addr[17:2]; upper address bits are ignored, so 0x8000_0000 aliases to word 0.
  - Byte lanes are little-endian: byte 0 is m[i][7:0].
- Reset (rst=1 at a clock edge):
  - pc <= RESET_PC.
  - rs[0..31] <= 0 and csr[0..4095] <= 0.
  - Memory is not cleared.
  - Reset mid-execution aborts the current instruction with no register or memory write.
- Execution, one instruction per clock:
  - Fetch m[pc[17:2]] combinationally; decode/execute combinationally.
  - Register/CSR/memory writes and the pc update occur on the next rising edge.
  - Latency is 1 cycle per instruction; there are no stalls.
- x0 reads 0 always; writes to x0 are discarded.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target & ~1).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU; SB/SH/SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
  - FENCE/FENCE.I (treated as NOP).
  - ECALL, EBREAK, MRET, CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI.
- Arithmetic: 32-bit wraparound with no overflow detection. Shift amounts use bits [4:0]. SRA/SRAI sign-extend.
- Loads: byte/half select via addr[1:0]; sign- or zero-extend per funct3. Misaligned accesses are not trapped and use lane bits as given.
- Stores: read-modify-write only the addressed byte lanes of one word; other lanes are preserved.
- CSR ops:
  - rd <= old csr value.
  - New value = src (RW), old | src (RS), old & ~src (RC). src is rs1 or zero-extended uimm[4:0].
  - RS/RC with src field 0 perform no write.
  - All 4096 addresses are plain storage; mhartid (0xF14) reads 0.
- ECALL: csr[0x341] mepc <= pc; csr[0x342] mcause <= 11; pc <= csr[0x305] mtvec & ~3. No rd write.
- EBREAK: same sequence with mcause <= 3.
- MRET: pc <= csr[0x341].
- Privilege levels are not modelled.
- Unknown opcodes execute as NOP (pc += 4).
- Simultaneous read and write of the same register in one instruction reads the old value.

Test Plan:
- Reset: hold rst for 1 cycle with memory holding NOPs (0x00000013) → pc=0 after reset, pc=0x10 after 4 cycles, all rs = 0.
- ALU: addi x1,x0,-1; andi x3,x1,0x0F0; sub x4,x0,x1 → x3=0x000000F0, x4=1, x1=0xFFFFFFFF.
- Load/store lanes: word 0x100 = 0x11223344; sb 0xAA at offset 1 → word = 0x1122AA44; lb returns 0xFFFFFFAA; lbu returns 0xAA; lh at offset 2 returns 0x00001122.
- Branch/jump: bne taken skips 1 instruction; jal x1,+8 sets x1 = pc+4; jalr target has bit0 cleared.
- Trap: csrrw x0,0x305 with 0x40, then ecall at 0x20 → pc=0x40, mepc=0x20, mcause=11; mret → pc=0x20.
- Compliance: load rv32ui-p-andi image, run 5000 cycles → rs[3] == 1 ("passed"); repeat for every rv32ui-p test.
